// File: rtl/keylock_pkg.sv
// Shared definitions for the keypad scanner and the lock controller.
package keylock_pkg;

  localparam int unsigned KP_ROWS = 4;
  localparam int unsigned KP_COLS = 4;

  // Command key codes (4*row + col) understood by the lock controller.
  localparam logic [3:0] KEY_LOCK   = 4'd9;
  localparam logic [3:0] KEY_REPRO  = 4'd8;
  localparam logic [3:0] KEY_CANCEL = 4'd7;

  typedef enum logic [1:0] {
    StScan,
    StPressDb,
    StHeld,
    StReleaseDb
  } scan_state_e;

  // True when exactly one active-low column is asserted.
  function automatic logic col_single(logic [KP_COLS-1:0] c);
    return $countones(~c) == 1;
  endfunction

  // Index of the lowest asserted (low) column; meaningful only for a single sample.
  function automatic logic [1:0] col_index(logic [KP_COLS-1:0] c);
    logic [1:0] idx;
    idx = '0;
    for (int i = KP_COLS - 1; i >= 0; i--) begin
      if (!c[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for asynchronous level inputs, with a configurable reset value.
module keypad_sync #(
  parameter int unsigned       Width    = 4,
  parameter logic [Width-1:0] ResetVal = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  // Two-stage capture; the first stage may go metastable, the second is used.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 key matrix scanner: drives one row at a time, debounces press and release,
// and reports each accepted key once with a one-cycle rdy strobe.
module keypad_scanner
  import keylock_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 8
) (
  input  logic               clk,
  input  logic               reset,
  output logic [KP_ROWS-1:0] row_n,
  input  logic [KP_COLS-1:0] col_n,
  output logic [3:0]         keypress,
  output logic               rdy,
  output logic               key_held
);

  localparam int unsigned SlotW = $clog2(SCAN_DIV);
  localparam int unsigned DbW   = $clog2(DEBOUNCE_CNT + 1);
  localparam int unsigned RowW  = $clog2(KP_ROWS);
  localparam int unsigned ColW  = $clog2(KP_COLS);

  localparam logic [SlotW-1:0] SlotLast = SlotW'(SCAN_DIV - 1);
  // Matching sample that brings db_cnt up to DEBOUNCE_CNT.
  localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CNT - 1);

  logic [KP_COLS-1:0] col_s;
  logic [SlotW-1:0]   slot_q;
  scan_state_e        state_q, state_d;
  logic [RowW-1:0]    row_q, row_d;
  logic [RowW-1:0]    cand_row_q, cand_row_d;
  logic [ColW-1:0]    cand_col_q, cand_col_d;
  logic [DbW-1:0]     db_cnt_q, db_cnt_d;
  logic [3:0]         keypress_q, keypress_d;
  logic               rdy_q, rdy_d;
  logic               held_q, held_d;

  logic               sample;
  logic               is_idle;
  logic               is_single;
  logic [ColW-1:0]    low_col;

  keypad_sync #(
    .Width   (KP_COLS),
    .ResetVal({KP_COLS{1'b1}})
  ) u_col_sync (
    .clk  (clk),
    .reset(reset),
    .d    (col_n),
    .q    (col_s)
  );

  assign sample    = (slot_q == SlotLast);
  assign is_idle   = (col_s == {KP_COLS{1'b1}});
  assign is_single = col_single(col_s);
  assign low_col   = col_index(col_s);

  // Row slot timer; columns are only looked at in the last cycle so rows can settle.
  always_ff @(posedge clk) begin
    if (reset || sample) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_q + SlotW'(1);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StScan;
      row_q      <= '0;
      cand_row_q <= '0;
      cand_col_q <= '0;
      db_cnt_q   <= '0;
      keypress_q <= '0;
      rdy_q      <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      cand_row_q <= cand_row_d;
      cand_col_q <= cand_col_d;
      db_cnt_q   <= db_cnt_d;
      keypress_q <= keypress_d;
      rdy_q      <= rdy_d;
      held_q     <= held_d;
    end
  end

  // Scan/debounce decisions, taken only at the sample point of each row slot.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    cand_row_d = cand_row_q;
    cand_col_d = cand_col_q;
    db_cnt_d   = db_cnt_q;
    keypress_d = keypress_q;
    rdy_d      = 1'b0;
    held_d     = held_q;
    if (sample) begin
      case (state_q)
        StScan: begin
          if (is_single) begin
            cand_row_d = row_q;
            cand_col_d = low_col;
            db_cnt_d   = '0;
            state_d    = StPressDb;
          end else begin
            row_d = row_q + RowW'(1);
          end
        end
        StPressDb: begin
          if (is_single && (low_col == cand_col_q)) begin
            db_cnt_d = db_cnt_q + DbW'(1);
            if (db_cnt_q == DbLast) begin
              keypress_d = {cand_row_q, cand_col_q};
              rdy_d      = 1'b1;
              held_d     = 1'b1;
              state_d    = StHeld;
            end
          end else begin
            state_d = StScan;
            row_d   = row_q + RowW'(1);
          end
        end
        StHeld: begin
          // Extra keys keep the matrix non-idle; they never produce a new strobe.
          if (is_idle) begin
            db_cnt_d = '0;
            state_d  = StReleaseDb;
          end
        end
        StReleaseDb: begin
          if (is_idle) begin
            db_cnt_d = db_cnt_q + DbW'(1);
            if (db_cnt_q == DbLast) begin
              held_d  = 1'b0;
              row_d   = row_q + RowW'(1);
              state_d = StScan;
            end
          end else begin
            state_d = StHeld;
          end
        end
        default: state_d = StScan;
      endcase
    end
  end

  assign row_n    = ~(KP_ROWS'(1) << row_q);
  assign keypress = keypress_q;
  assign rdy      = rdy_q;
  assign key_held = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a passive key matrix driven by randomized and
// directed key activity, compared cycle by cycle with a sample-level reference model.
module tb_keypad_scanner;
  import keylock_pkg::*;

  localparam int S   = 4;
  localparam int D   = 3;
  localparam int LAT = D * S + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  keypress;
  logic        rdy;
  logic        key_held;
  logic [15:0] keys = '0;  // bit 4*row+col set while that key is physically down

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV    (S),
    .DEBOUNCE_CNT(D)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .row_n   (row_n),
    .col_n   (col_n),
    .keypress(keypress),
    .rdy     (rdy),
    .key_held(key_held)
  );

  // Passive matrix: a column reads low when a pressed key joins it to the driven row.
  always_comb begin
    col_n = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row_n[r] && keys[4*r+c]) col_n[c] = 1'b0;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: works on whole sample points. mode 0 scanning, 1 confirming a press,
  // 2 key held, 3 confirming a release. Columns are seen two edges after they change.
  int         m_mode, m_row, m_col, m_cnt, m_slot, m_kp, m_nrdy;
  bit         m_rdy, m_held;
  logic [3:0] m_seen [2];
  int         cyc = 0;
  int         t_single, t_idle, t_rdy, t_release;
  int         n_rdy = 0;
  bit         held_prev = 1'b0;

  function automatic int lowest_zero(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (!v[i]) return i;
    return 0;
  endfunction

  task automatic model_step(input logic [3:0] c, input bit r);
    logic [3:0] v;
    int         zeros;
    if (r) begin
      m_mode = 0; m_row = 0; m_col = 0; m_cnt = 0; m_slot = 0; m_kp = 0;
      m_rdy = 1'b0; m_held = 1'b0;
      m_seen[0] = 4'hf; m_seen[1] = 4'hf;
      return;
    end
    v     = m_seen[1];
    zeros = $countones(~v);
    m_rdy = 1'b0;
    if (m_slot == S - 1) begin
      case (m_mode)
        0: if (zeros == 1) begin
             m_col = lowest_zero(v); m_cnt = 0; m_mode = 1; t_single = cyc;
           end else m_row = (m_row + 1) % 4;
        1: if (zeros == 1 && lowest_zero(v) == m_col) begin
             m_cnt++;
             if (m_cnt == D) begin
               m_kp = 4 * m_row + m_col; m_rdy = 1'b1; m_held = 1'b1; m_mode = 2; m_nrdy++;
             end
           end else begin
             m_mode = 0; m_row = (m_row + 1) % 4;
           end
        2: if (zeros == 0) begin m_cnt = 0; m_mode = 3; t_idle = cyc; end
        3: if (zeros == 0) begin
             m_cnt++;
             if (m_cnt == D) begin m_held = 1'b0; m_mode = 0; m_row = (m_row + 1) % 4; end
           end else m_mode = 2;
        default: m_mode = 0;
      endcase
    end
    m_slot    = (m_slot + 1) % S;
    m_seen[1] = m_seen[0];
    m_seen[0] = c;
  endtask

  // One clock: capture inputs mid-cycle, step model at the edge, compare just after it.
  task automatic tick();
    logic [3:0] c;
    bit         r;
    logic [3:0] er;
    @(negedge clk);
    c = col_n;
    r = reset;
    @(posedge clk);
    model_step(c, r);
    cyc++;
    #1;
    er = ~(4'b0001 << m_row);
    check_val("outputs", {22'd0, row_n, keypress, rdy, key_held},
              {22'd0, er, m_kp[3:0], m_rdy, m_held});
    if (rdy) begin n_rdy++; t_rdy = cyc; end
    if (held_prev && !key_held) t_release = cyc;
    held_prev = key_held;
  endtask

  task automatic wait_rdy(input string tag);
    int n = 0;
    int start = n_rdy;
    while (n_rdy == start && n < 200) begin tick(); n++; end
    check_val(tag, n_rdy != start, 1);
  endtask

  task automatic wait_release(input string tag);
    int n = 0;
    while (key_held && n < 200) begin tick(); n++; end
    check_val(tag, key_held, 0);
  endtask

  task automatic wait_mode(input int mode);
    int n = 0;
    while (m_mode != mode && n < 200) begin tick(); n++; end
  endtask

  initial begin
    int         r0;
    logic [3:0] er;
    logic [3:0] rows_seen;
    int         t_mark;

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_val("rst_row_n", row_n, 4'b1110);
    check_val("rst_keypress", keypress, 0);
    check_val("rst_rdy", rdy, 0);
    check_val("rst_key_held", key_held, 0);

    // Idle scan: rows rotate every S cycles, no strobe.
    r0 = n_rdy;
    for (int k = 0; k < 64; k++) begin
      er = ~(4'b0001 << ((k / S) % 4));
      check_val("idle_row_n", row_n, er);
      tick();
    end
    check_val("idle_no_rdy", n_rdy - r0, 0);
    check_val("idle_keypress", keypress, 0);

    // Clean press of row 2, column 1.
    r0 = n_rdy;
    keys = 16'b1 << 9;
    wait_rdy("press_rdy");
    check_val("press_latency", t_rdy - t_single, LAT);
    check_val("press_code", keypress, KEY_LOCK);
    check_val("press_held", key_held, 1);
    repeat (20) tick();
    keys = '0;
    wait_release("press_release");
    check_val("release_latency", t_release - t_idle, LAT);
    check_val("press_one_rdy", n_rdy - r0, 1);
    check_val("press_code_stable", keypress, KEY_LOCK);

    // Press bounce: key toggles on alternate samples while confirming, then settles.
    r0 = n_rdy;
    keys = 16'b1 << 8;
    wait_mode(1);
    for (int b = 0; b < 6; b++) begin
      keys = (b % 2 == 0) ? 16'h0 : (16'b1 << 8);
      repeat (S) tick();
    end
    keys = '0;
    repeat (2 * S) tick();
    check_val("bounce_no_rdy", n_rdy - r0, 0);
    keys = 16'b1 << 8;
    wait_rdy("bounce_then_rdy");
    check_val("bounce_code", keypress, KEY_REPRO);
    keys = '0;
    wait_release("bounce_release");
    check_val("bounce_one_rdy", n_rdy - r0, 1);

    // Release bounce: key lets go for one sample, comes back, then clean release.
    r0 = n_rdy;
    keys = 16'b1 << 7;
    wait_rdy("relb_rdy");
    repeat (8) tick();
    keys = '0;
    wait_mode(3);
    repeat (S) tick();
    keys = 16'b1 << 7;
    repeat (3 * S) tick();
    check_val("relb_still_held", key_held, 1);
    keys = '0;
    wait_release("relb_release");
    check_val("relb_one_rdy", n_rdy - r0, 1);
    check_val("relb_code", keypress, KEY_CANCEL);

    // Two keys in row 0: never accepted, scan keeps moving.
    r0 = n_rdy;
    rows_seen = '0;
    keys = 16'h0003;
    for (int k = 0; k < 64; k++) begin
      tick();
      rows_seen = rows_seen | ~row_n;
    end
    check_val("multi_no_rdy", n_rdy - r0, 0);
    check_val("multi_rows_scanned", rows_seen, 4'hf);
    keys = '0;
    repeat (2 * S) tick();

    // Extra keys while held: no second strobe.
    r0 = n_rdy;
    keys = 16'b1 << 5;
    wait_rdy("extra_rdy");
    keys = keys | (16'b1 << 6) | (16'b1 << 14);
    repeat (30) tick();
    keys = '0;
    wait_release("extra_release");
    check_val("extra_one_rdy", n_rdy - r0, 1);
    check_val("extra_code", keypress, 4'd5);

    // Reset lands in the cycle whose edge would raise rdy.
    r0 = n_rdy;
    keys = 16'b1 << 13;
    wait_mode(1);
    t_mark = t_single + D * S;
    while (cyc < t_mark) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("rstmid_rdy", rdy, 0);
    check_val("rstmid_row_n", row_n, 4'b1110);
    check_val("rstmid_key_held", key_held, 0);
    check_val("rstmid_keypress", keypress, 0);
    keys = '0;
    repeat (20) tick();
    check_val("rstmid_no_rdy", n_rdy - r0, 0);

    // Randomized presses with optional bounce and stray extra keys.
    r0 = n_rdy;
    m_nrdy = 0;
    for (int t = 0; t < 30; t++) begin
      int k;
      int nb;
      k  = $urandom_range(0, 15);
      nb = $urandom_range(0, 2);
      for (int b = 0; b < nb; b++) begin
        keys = 16'b1 << k;
        repeat ($urandom_range(1, 2 * S)) tick();
        keys = '0;
        repeat ($urandom_range(1, S)) tick();
      end
      keys = 16'b1 << k;
      if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, 15)] = 1'b1;
      repeat ($urandom_range(70, 120)) tick();
      keys = '0;
      repeat ($urandom_range(2 * D * S + 8, 60)) tick();
    end
    check_val("rand_rdy_count", n_rdy - r0, m_nrdy);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
